// File: rtl/hscale_mac_sequencer.sv
// Horizontal-scaler sequencer: walks a fixed-point phase across one input line and
// drives a 2-tap FIR MAC (window shift + coefficient pair) once per output pixel.
module hscale_mac_sequencer #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int POST_REGS = 0
) (
  input  logic              CLK_i,
  input  logic              nRST_i,
  input  logic              start_i,
  input  logic [11:0]       line_len_i,
  input  logic [12:0]       step_i,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic              pix_ready_o,
  output logic [1:0]        inopcode_o,
  output logic [1:0]        calcopcode_o,
  output logic [DATA_W-1:0] data_a0_o,
  output logic [COEF_W-1:0] coef_b0_o,
  output logic [COEF_W-1:0] coef_b1_o,
  output logic              mac_valid_o,
  output logic              busy_o,
  output logic              line_done_o
);

  localparam int         TOK_W     = 2 + POST_REGS;
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SHIFT  = 2'b10;
  localparam logic [1:0] CALC_NORM = 2'b00;
  localparam logic [1:0] CALC_BYP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [11:0]       phase_r, phase_s;
  logic [11:0]       out_cnt_r, out_cnt_s;
  logic [11:0]       len_r, len_s;
  logic [12:0]       step_r, step_s;
  logic [12:0]       sum_s;
  logic              adv_r, adv_s;
  logic              prime_cnt_r, prime_cnt_s;
  logic              issue_r, issue_s;
  logic [TOK_W-1:0]  tok_r;
  logic              accept_s, ready_s, done_s, empty_s;
  logic [1:0]        inop_s, calcop_s;
  logic [DATA_W-1:0] a0_s;
  logic [COEF_W-1:0] b0_s, b1_s, frac_s;

  // Next-state, phase accumulation and next drive-cycle contents.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    out_cnt_s   = out_cnt_r;
    len_s       = len_r;
    step_s      = step_r;
    adv_s       = adv_r;
    prime_cnt_s = prime_cnt_r;
    issue_s     = 1'b0;
    inop_s      = OP_NOP;
    calcop_s    = CALC_NORM;
    a0_s        = '0;
    b0_s        = '0;
    b1_s        = '0;
    accept_s    = pix_ready_o && pix_valid_i;
    frac_s      = phase_r[11 -: COEF_W];
    sum_s       = {1'b0, phase_r} + step_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          len_s       = line_len_i;
          step_s      = (step_i > 13'h1000) ? 13'h1000 : step_i;
          phase_s     = '0;
          out_cnt_s   = '0;
          adv_s       = 1'b0;
          prime_cnt_s = 1'b0;
          state_s     = (line_len_i == 12'd0) ? S_DRAIN : S_PRIME;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PRIME: begin
        if (accept_s) begin
          inop_s      = OP_SHIFT;
          a0_s        = pix_i;
          prime_cnt_s = 1'b1;
          state_s     = prime_cnt_r ? S_RUN : S_PRIME;
        end else begin
          state_s = S_PRIME;
        end
      end
      S_RUN: begin
        // With adv pending the issue must carry the next pixel, so it waits for one.
        if (!adv_r || accept_s) begin
          issue_s = 1'b1;
          if (adv_r) begin
            inop_s = OP_SHIFT;
            a0_s   = pix_i;
          end else begin
            inop_s = OP_NOP;
          end
          if (frac_s == '0) begin
            calcop_s = CALC_BYP;
          end else begin
            b0_s = frac_s;
            b1_s = {COEF_W{1'b0}} - frac_s;
          end
          phase_s   = sum_s[11:0];
          adv_s     = sum_s[12];
          out_cnt_s = out_cnt_r + 12'd1;
          state_s   = (out_cnt_s == len_r) ? S_DRAIN : S_RUN;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (line_done_o) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase
    // Look one cycle ahead so line_done_o is registered yet lands right after the last result.
    empty_s = !issue_s && !issue_r && (tok_r == '0);
    done_s  = (state_s == S_DRAIN) && empty_s;
    ready_s = (state_s == S_PRIME) || ((state_s == S_RUN) && adv_s);
  end

  // State, line context, token pipeline and registered outputs.
  always_ff @(posedge CLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_r      <= S_IDLE;
      phase_r      <= '0;
      out_cnt_r    <= '0;
      len_r        <= '0;
      step_r       <= '0;
      adv_r        <= 1'b0;
      prime_cnt_r  <= 1'b0;
      issue_r      <= 1'b0;
      tok_r        <= '0;
      pix_ready_o  <= 1'b0;
      inopcode_o   <= OP_NOP;
      calcopcode_o <= CALC_NORM;
      data_a0_o    <= '0;
      coef_b0_o    <= '0;
      coef_b1_o    <= '0;
      mac_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      line_done_o  <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      out_cnt_r    <= out_cnt_s;
      len_r        <= len_s;
      step_r       <= step_s;
      adv_r        <= adv_s;
      prime_cnt_r  <= prime_cnt_s;
      issue_r      <= issue_s;
      tok_r        <= {tok_r[TOK_W-2:0], issue_r};
      pix_ready_o  <= ready_s;
      inopcode_o   <= inop_s;
      calcopcode_o <= calcop_s;
      data_a0_o    <= a0_s;
      coef_b0_o    <= b0_s;
      coef_b1_o    <= b1_s;
      mac_valid_o  <= tok_r[TOK_W-1];
      busy_o       <= (state_s != S_IDLE);
      line_done_o  <= done_s;
    end
  end

endmodule

// File: tb/tb_hscale_mac_sequencer.sv
// Scoreboard bench: a position-based scaler reference predicts every drive cycle and
// MAC result; a monitor with a behavioural 2-tap MAC checks what the DUT produces.
module tb_hscale_mac_sequencer;
  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int POST_REGS = 0;
  localparam int LAT       = 3 + POST_REGS;
  localparam int PKT_W     = 5 + DATA_W + 2 * COEF_W;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       line_len = '0;
  logic [12:0]       step_in = '0;
  logic              pix_valid = 1'b0;
  logic [DATA_W-1:0] pix = '0;
  logic              pix_ready;
  logic [1:0]        inop, calcop;
  logic [DATA_W-1:0] a0;
  logic [COEF_W-1:0] b0, b1;
  logic              mac_valid, busy, line_done;

  typedef struct { logic [PKT_W-1:0] pkt; int res; } ev_t;
  typedef struct { int due; int got; int want; } pend_t;

  ev_t   expq[$];
  pend_t pend[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    px[64];

  hscale_mac_sequencer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .POST_REGS(POST_REGS)) dut (
    .CLK_i(clk), .nRST_i(nrst), .start_i(start), .line_len_i(line_len), .step_i(step_in),
    .pix_valid_i(pix_valid), .pix_i(pix), .pix_ready_o(pix_ready), .inopcode_o(inop),
    .calcopcode_o(calcop), .data_a0_o(a0), .coef_b0_o(b0), .coef_b1_o(b1),
    .mac_valid_o(mac_valid), .busy_o(busy), .line_done_o(line_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endfunction

  function automatic logic [PKT_W-1:0] mk(input bit iss, input bit sh, input int p,
                                          input int cop, input int c0, input int c1);
    return {iss, (sh ? 2'b10 : 2'b00), DATA_W'(p), 2'(cop), COEF_W'(c0), COEF_W'(c1)};
  endfunction

  // Monitor: behavioural MAC window plus drive-cycle and result scoreboard.
  int w0 = 0, w1 = 0;
  always @(negedge clk) begin : mon
    logic             is_iss, exp_mv;
    logic [PKT_W-1:0] got;
    ev_t              e;
    pend_t            p;
    int               res;
    if (!nrst) begin
      w0 = 0; w1 = 0;
      expq.delete();
      pend.delete();
    end else begin
      is_iss = (calcop == 2'b10) || (b0 != '0);
      got    = {is_iss, inop, a0, calcop, b0, b1};
      if (inop == 2'b10 || is_iss) begin
        if (inop == 2'b10) begin w1 = w0; w0 = int'(a0); end
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL drive_unexpected got %0h exp none", got);
        end else begin
          e = expq.pop_front();
          check("drive", got, e.pkt);
          if (is_iss) begin
            res = (calcop == 2'b10) ? w1 : (w0 * int'(b0) + w1 * int'(b1)) >> COEF_W;
            pend.push_back('{cyc + LAT, res, e.res});
          end
        end
      end else begin
        check("quiet_cycle", {a0, b1}, 0);
      end
      exp_mv = (pend.size() > 0) && (pend[0].due == cyc);
      if (mac_valid || exp_mv) begin
        check("mac_valid", mac_valid, exp_mv);
        if (exp_mv) begin
          p = pend.pop_front();
          if (mac_valid) check("mac_result", p.got, p.want);
        end
      end
    end
  end

  task automatic do_reset();
    int seen;
    pix_valid = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 check("reset_outputs", {pix_ready, inop, calcop, a0, b0, b1, mac_valid, busy, line_done}, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (line_done) seen++;
    end
    check("no_done_after_reset", seen, 0);
    check("idle_after_reset", busy, 0);
  endtask

  task automatic run_line(input int step, input int len, input int stall_idx, input int stall_cyc,
                          input int busy_start_at, input int abort_at);
    int se, npix, iprev, x, i, f, res, idx, stall_left, dones, extra;
    bit sh, aborted;
    se = (step > 'h1000) ? 'h1000 : step;
    npix = 0;
    iprev = 0;
    // Output n samples input position n*se/4096, between pixels i and i+1.
    if (len > 0) begin
      expq.push_back('{mk(0, 1, px[0], 0, 0, 0), 0});
      expq.push_back('{mk(0, 1, px[1], 0, 0, 0), 0});
      for (int n = 0; n < len; n++) begin
        x   = n * se;
        i   = x >> 12;
        f   = (x & 'hFFF) >> (12 - COEF_W);
        sh  = (n > 0) && (i != iprev);
        res = (f == 0) ? px[i] : (px[i+1] * f + px[i] * ((1 << COEF_W) - f)) >> COEF_W;
        expq.push_back('{mk(1, sh, sh ? px[i+1] : 0, (f == 0) ? 2 : 0, f,
                            (f == 0) ? 0 : (1 << COEF_W) - f), res});
        iprev = i;
      end
      npix = 2 + iprev;
    end
    @(negedge clk);
    start = 1'b1; line_len = 12'(len); step_in = 13'(step);
    @(negedge clk);
    start = 1'b0; line_len = 12'($urandom); step_in = 13'($urandom);
    if (len == 0) check("done_after_start", line_done, 1);
    check("busy_in_line", busy, 1);
    idx = 0; stall_left = stall_cyc; dones = 0; aborted = 1'b0;
    for (int it = 0; it < 3000 && dones == 0; it++) begin
      if (line_done) dones++;
      if (it == abort_at) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      start = (it == busy_start_at);
      if (idx < npix + 1 && !(idx == stall_idx && stall_left > 0 && pix_ready)) begin
        pix_valid = 1'b1;
        pix = DATA_W'(px[idx]);
      end else begin
        pix_valid = 1'b0;
        if (idx == stall_idx && stall_left > 0 && pix_ready) stall_left--;
      end
      if (pix_valid && pix_ready) idx++;
      @(negedge clk);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    if (!aborted) begin
      check("line_done_seen", dones, 1);
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (line_done) extra++;
      end
      check("single_done", extra, 0);
      check("pixels_accepted", idx, npix);
      check("expq_drained", expq.size(), 0);
      check("results_drained", pend.size(), 0);
      check("idle_after_line", busy, 0);
    end
  endtask

  task automatic load_px(input int p0, input int p1, input int p2, input int p3,
                         input int p4, input int p5);
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3; px[4] = p4; px[5] = p5;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {pix_ready, inop, calcop, a0, b0, b1, mac_valid, busy, line_done}, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("idle_not_busy", busy, 0);

    load_px(10, 20, 30, 40, 50, 60);
    run_line('h1000, 4, -1, 0, -1, -1);
    run_line('h1FFF, 4, -1, 0, -1, -1);
    load_px(0, 200, 100, 77, 5, 9);
    run_line('h0800, 4, -1, 0, -1, -1);
    run_line('h0800, 4, 2, 3, -1, -1);
    run_line('h0800, 0, -1, 0, -1, -1);
    run_line('h0800, 4, -1, 0, 3, -1);

    for (int k = 0; k < 64; k++) px[k] = $urandom_range(0, 255);
    run_line('h0C00, 20, -1, 0, -1, 8);
    load_px(0, 200, 100, 77, 5, 9);
    run_line('h0800, 4, -1, 0, -1, -1);

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 64; k++) px[k] = $urandom_range(0, 255);
      run_line($urandom_range(0, 'h1FFF), $urandom_range(1, 16), $urandom_range(0, 8),
               $urandom_range(0, 4), $urandom_range(0, 6), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hscale_mac_sequencer.md
HSCALE_MAC_SEQUENCER -- requirements
Module: hscale_mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width; equals the MAC's A-operand and output widths.
REQ-002 SHALL have parameter COEF_W, default 8, coefficient width; equals the MAC's B-operand width.
REQ-003 SHALL have parameter POST_REGS, default 0, the MAC's post-register count; sets the result-valid delay.
REQ-004 SHALL have port CLK_i  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port nRST_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start_i  in  1  line-start pulse; sampled only in IDLE.
REQ-007 SHALL have port line_len_i  in  12  output pixels per line; latched on start.
REQ-008 SHALL have port step_i  in  13  input/output ratio, unsigned 1.12; latched on start.
REQ-009 SHALL have port pix_valid_i  in  1  input pixel valid.
REQ-010 SHALL have port pix_i  in  DATA_W  input pixel.
REQ-011 SHALL have port pix_ready_o  out  1  pixel accepted when valid and ready are both high at a clock edge.
REQ-012 SHALL have port inopcode_o  out  2  MAC input opcode: 00 nop, 10 fir shift.
REQ-013 SHALL have port calcopcode_o  out  2  MAC calc opcode: 00 normal, 10 bypass a1.
REQ-014 SHALL have ports data_a0_o  out  DATA_W, coef_b0_o  out  COEF_W and coef_b1_o  out  COEF_W, the MAC operands.
REQ-015 SHALL have ports mac_valid_o  out  1, busy_o  out  1 and line_done_o  out  1 (one-cycle pulse).

Function
REQ-016 SHALL implement FSM IDLE -> PRIME -> RUN -> DRAIN -> IDLE, with busy_o high outside IDLE.
REQ-017 IDLE + start_i SHALL latch line_len_i and step_eff = min(step_i, 0x1000), clear phase and out_cnt, and go to PRIME; if line_len_i = 0, it SHALL go to DRAIN instead.
REQ-018 start_i outside IDLE SHALL be ignored.
REQ-019 PRIME SHALL assert pix_ready_o and accept exactly 2 pixels, each producing one registered drive cycle with inopcode_o = 10 and data_a0_o = pixel; it SHALL then go to RUN with window a1 = p0, a0 = p1.
REQ-020 An issue SHALL be a registered drive cycle in RUN carrying coefficients for the current window.
REQ-021 In an issue with f = phase[11:12-COEF_W] = 0, the block SHALL drive calcopcode_o = 10, with both coefficients don't-care and driven 0.
REQ-022 In an issue with f != 0, the block SHALL drive calcopcode_o = 00, coef_b0_o = f and coef_b1_o = 2^COEF_W - f.
REQ-023 After each issue, the block SHALL compute sum = phase + step_eff (13 bits), set phase = sum[11:0], and set adv = sum[12].
REQ-024 If adv is set, the next issue SHALL carry inopcode_o = 10 and data_a0_o = the accepted pixel in the same drive cycle; pix_ready_o SHALL be high only while adv is set and the issue is pending.
REQ-025 If adv is set and pix_valid_i is low, the block SHALL stall: no issue, inopcode_o = 00, phase and out_cnt held.
REQ-026 If adv is clear, the next issue SHALL carry inopcode_o = 00 and SHALL consume no pixel; at most one issue SHALL occur per cycle.
REQ-027 In every non-issue, non-shift drive cycle, the block SHALL drive inopcode_o = 00, calcopcode_o = 00, and all operands 0.
REQ-028 out_cnt SHALL increment per issue; when out_cnt reaches the latched length, the FSM SHALL go to DRAIN with no further pixel accepted.
REQ-029 mac_valid_o SHALL be high exactly 3+POST_REGS cycles after each issue cycle, via a shift-register token pipeline, and low otherwise.
REQ-030 DRAIN SHALL wait until the token pipeline is empty, then pulse line_done_o for 1 cycle and return to IDLE; for a zero-length line, the pulse SHALL occur in the cycle after start.
REQ-031 A stall mid-line SHALL create gaps in mac_valid_o and SHALL NOT cause loss or duplication of outputs.

Reset
REQ-032 nRST_i low SHALL asynchronously force IDLE, phase = 0, adv = 0, out_cnt = 0, empty token pipeline, and all outputs 0 (pix_ready_o, busy_o, mac_valid_o, line_done_o, opcodes, operands).
REQ-033 Reset mid-line SHALL abandon the line with no line_done_o pulse; the first start_i after release SHALL behave as from power-up.

Verification
REQ-034 Bench SHALL cover: step 0x1000, len 4, pixels 10,20,30,40,50 continuous -> 5 accepted, all issues calcop 10, MAC results 10,20,30,40, one line_done_o.
REQ-035 Bench SHALL cover: step 0x0800, len 4, pixels 0,200,100 -> issue coefs (-,-), (128,128), (-,-), (128,128); results 0,100,200,150.
REQ-036 Bench SHALL cover: the REQ-035 stimulus with pix_valid_i low for 3 cycles when the third pixel is requested -> 3 stall cycles with inopcode 00, identical results, mac_valid_o gap of 3.
REQ-037 Bench SHALL cover: step 0x1FFF -> behaviour identical to step 0x1000.
REQ-038 Bench SHALL cover: len 0 -> line_done_o the cycle after start, no pixel accepted, no mac_valid_o.
REQ-039 Bench SHALL cover: reset asserted during RUN, and start_i pulsed while busy -> all outputs 0 immediately, no line_done_o, next line correct; start while busy ignored.
